vt100_report_encoder: RTL and testbench

Host-bound byte generator for the virtual console: converts local key events and terminal status reports into VT100 byte sequences for the UART transmitter. It sits between the keyboard front end and the UART TX, beside the VT100 parser. The parser raises report requests (cursor position report, device attributes); this block serialises the answer one byte per handshake.

---
 rtl/vt100_report_encoder.sv | 205 ++++++++++++++++++++
 tb/tb_vt100_report_encoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vt100_report_encoder.sv
// Host-bound VT100 byte generator: turns key events, cursor position reports and device
// attribute reports into byte sequences, one per txValid/txReady handshake. Macro: VT100_APP_CURSOR_EN.
module vt100_report_encoder #(
  parameter int MAX_SEQ_LEN = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       keyValid,
  input  logic [7:0] keyCode,
  output logic       keyReady,
  input  logic       appCursorMode,
  input  logic       cprReq,
  input  logic [7:0] cursorX,
  input  logic [7:0] cursorY,
  input  logic       daReq,
  output logic       txValid,
  output logic [7:0] txData,
  input  logic       txReady
);

  localparam int LW = $clog2(MAX_SEQ_LEN + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  localparam logic [7:0] ESC = 8'h1B;

  // Handshakes: a byte moves when txValid && txReady; a key is taken when keyValid && keyReady.
  logic [0:0]    state;
  logic          cprPend;
  logic          daPend;
  logic [8:0]    capRow;
  logic [8:0]    capCol;
  logic [7:0]    seqBuf [MAX_SEQ_LEN];
  logic [LW-1:0] seqLen;
  logic [LW-1:0] idx;
  logic [LW-1:0] idxNext;

  logic [7:0]    cprBuf [MAX_SEQ_LEN];
  logic [LW-1:0] cprLen;
  logic [7:0]    keyBuf [MAX_SEQ_LEN];
  logic [LW-1:0] keyLen;
  logic [7:0]    loadBuf [MAX_SEQ_LEN];
  logic [LW-1:0] loadLen;
  logic [7:0]    cursorIntro;
  logic [7:0]    keyFinal;
  logic [23:0]   rowDigits;
  logic [23:0]   colDigits;
  logic [LW-1:0] p;
  logic          serveCpr;
  logic          serveDa;
  logic          keyFire;
  logic          doLoad;

`ifdef VT100_APP_CURSOR_EN
  assign cursorIntro = appCursorMode ? 8'h4F : 8'h5B;
`else
  logic unusedAppCursor;
  assign unusedAppCursor = appCursorMode;
  assign cursorIntro = 8'h5B;
`endif

  // Three ASCII digits {hundreds, tens, ones} of a value in 1..256.
  function automatic logic [23:0] decDigits(input logic [8:0] v);
    logic [3:0] h, t, o;
    h = 4'(v / 9'd100);
    t = 4'((v / 9'd10) % 9'd10);
    o = 4'(v % 9'd10);
    return {4'h3, h, 4'h3, t, 4'h3, o};
  endfunction

  assign keyReady = (state == IDLE) && !cprPend && !daPend && !rst;
  assign serveCpr = (state == IDLE) && cprPend;
  assign serveDa  = (state == IDLE) && !cprPend && daPend;
  assign keyFire  = keyValid && keyReady;
  assign doLoad   = serveCpr || serveDa || (keyFire && keyLen != '0);
  assign idxNext  = idx + LW'(1);

  assign rowDigits = decDigits(capRow);
  assign colDigits = decDigits(capCol);

  // CPR text: leading zeros are suppressed by skipping the hundreds/tens positions.
  always_comb begin
    for (int i = 0; i < MAX_SEQ_LEN; i++) cprBuf[i] = 8'h00;
    cprBuf[0] = ESC;
    cprBuf[1] = 8'h5B;
    p = LW'(2);
    if (capRow >= 9'd100) begin cprBuf[p] = rowDigits[23:16]; p = p + LW'(1); end
    if (capRow >= 9'd10)  begin cprBuf[p] = rowDigits[15:8];  p = p + LW'(1); end
    cprBuf[p] = rowDigits[7:0];
    p = p + LW'(1);
    cprBuf[p] = 8'h3B;
    p = p + LW'(1);
    if (capCol >= 9'd100) begin cprBuf[p] = colDigits[23:16]; p = p + LW'(1); end
    if (capCol >= 9'd10)  begin cprBuf[p] = colDigits[15:8];  p = p + LW'(1); end
    cprBuf[p] = colDigits[7:0];
    p = p + LW'(1);
    cprBuf[p] = 8'h52;
    cprLen = p + LW'(1);
  end

  always_comb begin
    for (int i = 0; i < MAX_SEQ_LEN; i++) keyBuf[i] = 8'h00;
    keyLen = '0;
    case (keyCode[3:0])
      4'h0:    keyFinal = 8'h41;
      4'h1:    keyFinal = 8'h42;
      4'h2:    keyFinal = 8'h43;
      4'h3:    keyFinal = 8'h44;
      4'h4:    keyFinal = 8'h48;
      4'h5:    keyFinal = 8'h46;
      4'h6:    keyFinal = 8'h50;
      4'h7:    keyFinal = 8'h51;
      4'h8:    keyFinal = 8'h52;
      4'h9:    keyFinal = 8'h53;
      default: keyFinal = 8'h00;
    endcase
    if (!keyCode[7]) begin
      keyBuf[0] = keyCode;
      keyLen = LW'(1);
    end else if (keyCode <= 8'h89) begin
      keyBuf[0] = ESC;
      keyBuf[1] = (keyCode >= 8'h86) ? 8'h4F : cursorIntro;
      keyBuf[2] = keyFinal;
      keyLen = LW'(3);
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_SEQ_LEN; i++) loadBuf[i] = keyBuf[i];
    loadLen = keyLen;
    if (serveCpr) begin
      for (int i = 0; i < MAX_SEQ_LEN; i++) loadBuf[i] = cprBuf[i];
      loadLen = cprLen;
    end else if (serveDa) begin
      for (int i = 0; i < MAX_SEQ_LEN; i++) loadBuf[i] = 8'h00;
      loadBuf[0] = ESC;
      loadBuf[1] = 8'h5B;
      loadBuf[2] = 8'h3F;
      loadBuf[3] = 8'h31;
      loadBuf[4] = 8'h3B;
      loadBuf[5] = 8'h32;
      loadBuf[6] = 8'h63;
      loadLen = LW'(7);
    end
  end

  // A new request in the same cycle its flag is served re-arms the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cprPend <= 1'b0;
      daPend  <= 1'b0;
      capRow  <= '0;
      capCol  <= '0;
    end else begin
      if (cprReq) begin
        cprPend <= 1'b1;
        capRow  <= {1'b0, cursorY} + 9'd1;
        capCol  <= {1'b0, cursorX} + 9'd1;
      end else if (serveCpr) begin
        cprPend <= 1'b0;
      end
      if (daReq)        daPend <= 1'b1;
      else if (serveDa) daPend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      seqLen  <= '0;
      txValid <= 1'b0;
      txData  <= 8'h00;
      for (int i = 0; i < MAX_SEQ_LEN; i++) seqBuf[i] <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (doLoad) begin
            for (int i = 0; i < MAX_SEQ_LEN; i++) seqBuf[i] <= loadBuf[i];
            seqLen  <= loadLen;
            idx     <= '0;
            txValid <= 1'b1;
            txData  <= loadBuf[0];
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (txReady) begin
            if (idx == seqLen - LW'(1)) begin
              txValid <= 1'b0;
              idx     <= '0;
              state   <= IDLE;
            end else begin
              idx    <= idxNext;
              txData <= seqBuf[idxNext];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vt100_report_encoder.sv
// Directed bench for vt100_report_encoder: key, CPR, DA, back-to-back reports, stalls and reset abort.
module tb_vt100_report_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       keyValid;
  logic [7:0] keyCode;
  logic       keyReady;
  logic       appCursorMode;
  logic       cprReq;
  logic [7:0] cursorX;
  logic [7:0] cursorY;
  logic       daReq;
  logic       txValid;
  logic [7:0] txData;
  logic       txReady;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];

  vt100_report_encoder dut (
    .clk(clk), .rst(rst),
    .keyValid(keyValid), .keyCode(keyCode), .keyReady(keyReady),
    .appCursorMode(appCursorMode),
    .cprReq(cprReq), .cursorX(cursorX), .cursorY(cursorY), .daReq(daReq),
    .txValid(txValid), .txData(txData), .txReady(txReady)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expectSeq(input logic [79:0] bytes, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(bytes[(n-1-i)*8 +: 8]);
  endtask

  task automatic sendKey(input logic [7:0] code);
    @(negedge clk);
    keyValid = 1'b1;
    keyCode  = code;
    checkVal("key_ready", 32'(keyReady), 32'd1);
    @(posedge clk);
    #1 keyValid = 1'b0;
  endtask

  task automatic pulseReq(input logic cpr, input logic da, input logic [7:0] y, input logic [7:0] x);
    @(negedge clk);
    cprReq  = cpr;
    daReq   = da;
    cursorY = y;
    cursorX = x;
    @(posedge clk);
    #1;
    cprReq = 1'b0;
    daReq  = 1'b0;
  endtask

  // Consume exp_q against transfers; stalled bytes must hold until taken.
  task automatic drain(input int limit, input bit rnd, input bit chkKeyLow);
    int cyc = 0;
    bit stalled = 1'b0;
    logic [7:0] held = 8'h00;
    while (exp_q.size() > 0 && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        checkVal("stall_valid", 32'(txValid), 32'd1);
        checkVal("stall_hold", 32'(txData), 32'(held));
      end
      if (chkKeyLow) checkVal("report_keyready_low", 32'(keyReady), 32'd0);
      txReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 1'b0;
      if (txValid) begin
        if (txReady) checkVal("tx_byte", 32'(txData), 32'(exp_q.pop_front()));
        else begin
          stalled = 1'b1;
          held = txData;
        end
      end
    end
    if (exp_q.size() > 0) begin
      checkVal("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    txReady = 1'b1;
  endtask

  initial begin
    bit sawValid;
    rst = 1'b1;
    keyValid = 1'b0;
    keyCode = 8'h00;
    appCursorMode = 1'b0;
    cprReq = 1'b0;
    daReq = 1'b0;
    cursorX = 8'h00;
    cursorY = 8'h00;
    txReady = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    checkVal("rst_txValid", 32'(txValid), 32'd0);
    checkVal("rst_txData", 32'(txData), 32'h00);
    checkVal("rst_keyReady", 32'(keyReady), 32'd0);
    rst = 1'b0;
    #1 checkVal("post_rst_keyReady", 32'(keyReady), 32'd1);

    // Single ASCII key: first byte one cycle after load, valid for one cycle
    @(negedge clk);
    keyValid = 1'b1;
    keyCode = 8'h41;
    checkVal("key41_ready", 32'(keyReady), 32'd1);
    @(posedge clk);
    #1 keyValid = 1'b0;
    @(negedge clk);
    checkVal("key41_valid", 32'(txValid), 32'd1);
    checkVal("key41_data", 32'(txData), 32'h41);
    @(negedge clk);
    checkVal("key41_one_cycle", 32'(txValid), 32'd0);

    // CPR row 1 col 256
    pulseReq(1'b1, 1'b0, 8'd0, 8'd255);
    checkVal("cpr_keyready_after_req", 32'(keyReady), 32'd0);
    expectSeq(80'h1B5B313B32353652, 8);
    drain(100, 1'b0, 1'b1);

    // Cursor up in both modes, plus F1, End and an ignored code
    appCursorMode = 1'b1;
    sendKey(8'h80);
`ifdef VT100_APP_CURSOR_EN
    expectSeq(80'h1B4F41, 3);
`else
    expectSeq(80'h1B5B41, 3);
`endif
    drain(50, 1'b0, 1'b0);
    appCursorMode = 1'b0;
    sendKey(8'h80);
    expectSeq(80'h1B5B41, 3);
    drain(50, 1'b0, 1'b0);
    sendKey(8'h85);
    expectSeq(80'h1B5B46, 3);
    drain(50, 1'b0, 1'b0);
    appCursorMode = 1'b1;
    sendKey(8'h86);
    expectSeq(80'h1B4F50, 3);
    drain(50, 1'b0, 1'b0);
    appCursorMode = 1'b0;
    sendKey(8'h8A);
    sawValid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (txValid) sawValid = 1'b1;
    end
    checkVal("key8A_silent", 32'(sawValid), 32'd0);
    checkVal("key8A_idle_ready", 32'(keyReady), 32'd1);

    // CPR and DA together: CPR, one idle cycle, then DA
    pulseReq(1'b1, 1'b1, 8'd4, 8'd9);
    expectSeq(80'h1B5B353B313052, 7);
    drain(100, 1'b0, 1'b1);
    @(negedge clk);
    checkVal("cpr_da_gap", 32'(txValid), 32'd0);
    expectSeq(80'h1B5B3F313B3263, 7);
    drain(100, 1'b0, 1'b0);

    // Key accepted in the same cycle as a request: key first, then report
    @(negedge clk);
    keyValid = 1'b1;
    keyCode = 8'h61;
    cprReq = 1'b1;
    cursorY = 8'd0;
    cursorX = 8'd0;
    checkVal("race_key_ready", 32'(keyReady), 32'd1);
    @(posedge clk);
    #1;
    keyValid = 1'b0;
    cprReq = 1'b0;
    checkVal("race_keyready_drop", 32'(keyReady), 32'd0);
    expectSeq(80'h61, 1);
    expectSeq(80'h1B5B313B3152, 6);
    drain(100, 1'b0, 1'b0);

    // DA under random backpressure
    pulseReq(1'b0, 1'b1, 8'd0, 8'd0);
    expectSeq(80'h1B5B3F313B3263, 7);
    drain(300, 1'b1, 1'b1);

    // Reset mid-CPR (row 100 col 200) with a DA pending behind it
    pulseReq(1'b1, 1'b0, 8'd99, 8'd199);
    pulseReq(1'b0, 1'b1, 8'd99, 8'd199);
    expectSeq(80'h1B5B31, 3);
    drain(50, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 checkVal("rst_abort_valid", 32'(txValid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 checkVal("rst_abort_keyReady", 32'(keyReady), 32'd1);
    sawValid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (txValid) sawValid = 1'b1;
    end
    checkVal("rst_abort_no_resume", 32'(sawValid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
